// File: rtl/imm_pipe_unit.sv
// imm_pipe_unit: registered LEGv8 immediate generator with valid/ready handshake and flush
// Ports: clk; reset (async, active-high); in_valid/in_ready/instruction from IF/ID;
// flush drops held and incoming work; out_valid/out_ready/imm/fmt/err toward ID/EX.
module imm_pipe_unit #(
  parameter int WORD = 64,
  parameter int INSTR_LEN = 32,
  parameter int BRANCH_SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      imm,
  output logic [2:0]           fmt,
  output logic                 err
);
  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_D    = 3'd2;
  localparam logic [2:0] F_CB   = 3'd3;
  localparam logic [2:0] F_B    = 3'd4;
  localparam logic [2:0] F_IM   = 3'd5;
  localparam logic [2:0] F_SH   = 3'd6;
  logic is_b, is_cb, is_im, is_i, is_d, is_sh, im_err, nxt_err, unused;
  logic [WORD-1:0] b_raw, cb_raw, b_imm, cb_imm, im_imm, i_imm, d_imm, sh_imm, nxt_imm;
  logic [2:0] nxt_fmt;
  assign unused = ^instruction[4:0];
  assign is_b  = instruction[31:26] inside {6'b000101, 6'b100101};
  assign is_cb = instruction[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100};
  assign is_im = instruction[31:23] inside {9'b110100101, 9'b111100101};
  assign is_i  = instruction[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100,
                                            10'b1111000100, 10'b1001001000, 10'b1111001000,
                                            10'b1011001000, 10'b1101001000};
  assign is_d  = instruction[31:21] inside {11'b11111000010, 11'b11111000000};
  assign is_sh = instruction[31:21] inside {11'b11010011011, 11'b11010011010};
  assign b_raw  = {{(WORD-26){instruction[25]}}, instruction[25:0]};
  assign cb_raw = {{(WORD-19){instruction[23]}}, instruction[23:5]};
  assign b_imm  = BRANCH_SHIFT != 0 ? b_raw << 2 : b_raw;
  assign cb_imm = BRANCH_SHIFT != 0 ? cb_raw << 2 : cb_raw;
  // hw>=2 would shift the whole halfword out of a 32-bit word
  assign im_err = (WORD == 32) && instruction[22];
  assign im_imm = im_err ? '0 : {{(WORD-16){1'b0}}, instruction[20:5]} << {instruction[22:21], 4'b0000};
  assign i_imm  = {{(WORD-12){1'b0}}, instruction[21:10]};
  assign d_imm  = {{(WORD-9){instruction[20]}}, instruction[20:12]};
  assign sh_imm = {{(WORD-6){1'b0}}, instruction[15:10]};
  assign nxt_fmt = is_b ? F_B : is_cb ? F_CB : is_im ? F_IM : is_i ? F_I :
                   is_d ? F_D : is_sh ? F_SH : F_NONE;
  assign nxt_imm = is_b ? b_imm : is_cb ? cb_imm : is_im ? im_imm : is_i ? i_imm :
                   is_d ? d_imm : is_sh ? sh_imm : '0;
  assign nxt_err = !is_b && !is_cb && is_im && im_err;
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      imm       <= '0;
      fmt       <= F_NONE;
      err       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      imm       <= nxt_imm;
      fmt       <= nxt_fmt;
      err       <= nxt_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
